// File: rtl/booth_bist_ctrl.sv
// -----------------------------------------------------------------------------
// booth_bist_ctrl
//
// Built-in self-test controller for the 4-bit Booth multiplier. A test run
// takes NPAT operand pairs from an 8-bit LFSR. Each pair is issued with a
// one-cycle start pulse. The controller then waits for the multiplier's busy
// handshake to rise and fall, and folds the product into an 8-bit MISR. At the
// end of the run the signature is compared against GOLDEN to produce pass.
//
// Parameters
//   WIDTH     operand width (only 4 is supported; product is 2*WIDTH bits)
//   NPAT      operand pairs applied per run (1..255)
//   SEED      LFSR seed; 8'h00 is replaced by 8'h01
//   GOLDEN    expected final MISR signature
//   MAX_WAIT  cycle limit for each busy-rise / busy-fall wait (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   test_start   one-cycle run request; only honoured while idle
//   mul_a/mul_b  operands to the multiplier; held from issue until sampled
//   mul_start    one-cycle start pulse to the multiplier
//   mul_busy     multiplier busy
//   mul_product  multiplier result (raw bits)
//   test_busy    high from acceptance of a run until done
//   test_done    high from end of run until the next accepted test_start
//   pass         valid while test_done: signature matched and no timeout
//   signature    current MISR value
// -----------------------------------------------------------------------------
module booth_bist_ctrl #(
  parameter int          WIDTH    = 4,
  parameter int          NPAT     = 16,
  parameter logic [7:0]  SEED     = 8'h01,
  parameter logic [7:0]  GOLDEN   = 8'h00,
  parameter int          MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               test_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic               mul_busy,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               test_busy,
  output logic               test_done,
  output logic               pass,
  output logic [7:0]         signature
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] NPAT_L    = 8'(NPAT);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    COMPACT,
    FINISH
  } state_t;

  state_t       state, state_n;
  logic [7:0]   lfsr, lfsr_n;
  logic [7:0]   misr, misr_n;
  logic [7:0]   pat_cnt, pat_cnt_n;
  logic [7:0]   wait_cnt, wait_cnt_n;
  logic [7:0]   prod_q, prod_n;
  logic         timeout, timeout_n;
  logic         done_q, done_n;
  logic         pass_q, pass_n;

  logic [7:0]   lfsr_step;
  logic [7:0]   misr_step;
  logic [7:0]   cnt_inc;
  logic         ops_valid;

  // Both shift registers use the same feedback taps (7,5,4,3).
  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_step = {misr[6:0], misr[7] ^ misr[5] ^ misr[4] ^ misr[3]};
  assign cnt_inc   = pat_cnt + 8'd1;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_n    = state;
    lfsr_n     = lfsr;
    misr_n     = misr;
    pat_cnt_n  = pat_cnt;
    wait_cnt_n = wait_cnt;
    prod_n     = prod_q;
    timeout_n  = timeout;
    done_n     = done_q;
    pass_n     = pass_q;
    mul_start  = 1'b0;

    case (state)
      IDLE: begin
        if (test_start) begin
          lfsr_n    = SEED_EFF;
          misr_n    = 8'h00;
          pat_cnt_n = 8'h00;
          timeout_n = 1'b0;
          done_n    = 1'b0;
          pass_n    = 1'b0;
          state_n   = ISSUE;
        end
      end

      ISSUE: begin
        mul_start  = 1'b1;
        wait_cnt_n = 8'h00;
        state_n    = WAIT_HI;
      end

      // Only a busy that is actually seen high counts; a low busy here means
      // the multiplier has not started yet, not that it has finished.
      WAIT_HI: begin
        if (mul_busy) begin
          wait_cnt_n = 8'h00;
          state_n    = WAIT_LO;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_n = 1'b1;
          state_n   = FINISH;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end

      WAIT_LO: begin
        if (!mul_busy) begin
          prod_n  = mul_product;
          state_n = COMPACT;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_n = 1'b1;
          state_n   = FINISH;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end

      COMPACT: begin
        misr_n    = misr_step ^ prod_q;
        lfsr_n    = lfsr_step;
        pat_cnt_n = cnt_inc;
        state_n   = (cnt_inc == NPAT_L) ? FINISH : ISSUE;
      end

      FINISH: begin
        pass_n  = (misr == GOLDEN) && !timeout;
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED_EFF;
      misr     <= 8'h00;
      pat_cnt  <= 8'h00;
      wait_cnt <= 8'h00;
      prod_q   <= 8'h00;
      timeout  <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state    <= state_n;
      lfsr     <= lfsr_n;
      misr     <= misr_n;
      pat_cnt  <= pat_cnt_n;
      wait_cnt <= wait_cnt_n;
      prod_q   <= prod_n;
      timeout  <= timeout_n;
      done_q   <= done_n;
      pass_q   <= pass_n;
    end
  end

  // Operands are driven only while a pattern is in flight and are zero
  // otherwise; the LFSR does not move until COMPACT, so they stay stable.
  assign ops_valid = (state == ISSUE) || (state == WAIT_HI) || (state == WAIT_LO);
  assign mul_a     = ops_valid ? lfsr[2*WIDTH-1:WIDTH] : '0;
  assign mul_b     = ops_valid ? lfsr[WIDTH-1:0]       : '0;

  assign test_busy = (state != IDLE);
  assign test_done = done_q;
  assign pass      = pass_q;
  assign signature = misr;

endmodule

// File: tb/tb_booth_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_bist_ctrl
//
// Six controller instances, each with its own multiplier stub:
//   u0  zero product, NPAT=16, GOLDEN=00  (reset abort, operand sequence)
//   u1  product FF,   NPAT=2,  GOLDEN=01  (pass)
//   u2  product FF,   NPAT=2,  GOLDEN=02  (fail)
//   u3  busy never rises                   (timeout)
//   u4  signed 4x4 product, GOLDEN from model, mid-run test_start ignored
//   u5  signed product with bit 0 stuck at 0, same GOLDEN (fail)
// Stimulus pushes expected run results into per-instance queues; a monitor
// per instance pops and compares when test_done rises.
// -----------------------------------------------------------------------------
module tb_booth_bist_ctrl;

  localparam int NI       = 6;
  localparam int BUSY_LEN = 4;

  localparam int M_ZERO  = 0;
  localparam int M_FF    = 1;
  localparam int M_DEAD  = 2;
  localparam int M_REAL  = 3;
  localparam int M_STUCK = 4;

  typedef struct {
    logic       pass;
    logic [7:0] sig;
    int         starts;
    int         cycles;
  } exp_t;

  // Stub multiplier result for a given mode.
  function automatic logic [7:0] stub_prod(input int mode, input logic [3:0] a,
                                           input logic [3:0] b);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    logic signed [7:0] sp;
    logic [7:0]        r;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    sp = sa * sb;
    case (mode)
      M_ZERO:  r = 8'h00;
      M_FF:    r = 8'hFF;
      M_STUCK: r = sp & 8'hFE;
      default: r = sp;
    endcase
    return r;
  endfunction

  // Reference signature: LFSR from seed 01, products through the MISR.
  function automatic logic [7:0] model_sig(input int npat, input int mode);
    logic [7:0] l;
    logic [7:0] m;
    l = 8'h01;
    m = 8'h00;
    for (int k = 0; k < npat; k++) begin
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ stub_prod(mode, l[7:4], l[3:0]);
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD_REAL  = model_sig(16, M_REAL);
  localparam logic [7:0] GOLD_STUCK = model_sig(16, M_STUCK);

  localparam int         NPAT_T [NI] = '{16, 2, 2, 16, 16, 16};
  localparam int         MODE_T [NI] = '{M_ZERO, M_FF, M_FF, M_DEAD, M_REAL, M_STUCK};
  localparam logic [7:0] GOLD_T [NI] = '{8'h00, 8'h01, 8'h02, 8'h00, GOLD_REAL, GOLD_REAL};

  logic          clk;
  logic          rst;
  logic [NI-1:0] ts_v;
  wire  [NI-1:0] done_v;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g
    logic       ts;
    logic       mbusy;
    logic       mstart;
    logic       tbusy;
    logic       tdone;
    logic       tpass;
    logic [3:0] ma;
    logic [3:0] mb;
    logic [7:0] prod;
    logic [7:0] sig;
    int         bcnt;

    exp_t       exp_q [$];
    logic [7:0] ops_q [$];
    logic [7:0] sig_q [$];

    assign ts        = ts_v[i];
    assign done_v[i] = tdone;

    booth_bist_ctrl #(
      .WIDTH    (4),
      .NPAT     (NPAT_T[i]),
      .SEED     (8'h01),
      .GOLDEN   (GOLD_T[i]),
      .MAX_WAIT (15)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .test_start  (ts),
      .mul_a       (ma),
      .mul_b       (mb),
      .mul_start   (mstart),
      .mul_busy    (mbusy),
      .mul_product (prod),
      .test_busy   (tbusy),
      .test_done   (tdone),
      .pass        (tpass),
      .signature   (sig)
    );

    // Multiplier stub: busy for BUSY_LEN cycles after a sampled start.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mbusy <= 1'b0;
        bcnt  <= 0;
        prod  <= 8'h00;
      end else if (mbusy) begin
        if (bcnt == 0) mbusy <= 1'b0;
        else           bcnt  <= bcnt - 1;
      end else if (mstart && MODE_T[i] != M_DEAD) begin
        mbusy <= 1'b1;
        bcnt  <= BUSY_LEN - 1;
        prod  <= stub_prod(MODE_T[i], ma, mb);
      end
    end

    // Monitor / scoreboard
    initial begin
      bit         armed     = 1'b0;
      bit         done_d    = 1'b0;
      bit         cur_valid = 1'b0;
      logic [7:0] cur_op    = 8'h00;
      int         starts    = 0;
      int         cyc       = 0;
      exp_t       e;
      forever begin
        @(negedge clk);
        if (rst) begin
          armed     = 1'b0;
          done_d    = 1'b0;
          cur_valid = 1'b0;
          exp_q.delete();
          ops_q.delete();
          sig_q.delete();
        end else begin
          if (armed) cyc++;
          if (ts && !tbusy && !armed) begin
            armed  = 1'b1;
            cyc    = 0;
            starts = 0;
          end
          if (mstart && armed) begin
            starts++;
            cur_valid = 1'b0;
            if (ops_q.size() > 0) begin
              cur_op    = ops_q.pop_front();
              cur_valid = 1'b1;
              check($sformatf("u%0d_operands_at_start", i), {ma, mb}, cur_op);
            end
            if (sig_q.size() > 0)
              check($sformatf("u%0d_sig_at_start", i), sig, sig_q.pop_front());
          end
          if (mbusy && cur_valid)
            check($sformatf("u%0d_operands_held", i), {ma, mb}, cur_op);
          if (tdone && !done_d) begin
            if (exp_q.size() == 0) begin
              check($sformatf("u%0d_spurious_done", i), 1'b1, 1'b0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("u%0d_pass", i), tpass, e.pass);
              check($sformatf("u%0d_signature", i), sig, e.sig);
              check($sformatf("u%0d_start_pulses", i), starts, e.starts);
              check($sformatf("u%0d_run_cycles", i), cyc, e.cycles);
              check($sformatf("u%0d_busy_low_at_done", i), tbusy, 1'b0);
            end
            armed     = 1'b0;
            cur_valid = 1'b0;
          end
          done_d = tdone;
        end
      end
    end
  end

  task automatic pulse_start(input logic [NI-1:0] mask);
    @(posedge clk);
    #1 ts_v = mask;
    @(posedge clk);
    #1 ts_v = '0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (!done_v[i] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("u%0d_done_within_budget", i), done_v[i], 1'b1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    rst  = 1'b1;
    ts_v = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_test_busy", g[0].tbusy, 1'b0);
    check("reset_test_done", g[0].tdone, 1'b0);
    check("reset_pass",      g[0].tpass, 1'b0);
    check("reset_signature", g[0].sig,   8'h00);
    check("reset_mul_start", g[0].mstart, 1'b0);
    rst = 1'b0;

    // Abort a run with an asynchronous reset in WAIT_LO of pattern 3.
    pulse_start(6'b000001);
    repeat (16) @(posedge clk);
    #3;
    check("pre_reset_busy",  g[0].tbusy, 1'b1);
    check("pre_reset_mul_b", g[0].mb,    4'h4);
    rst = 1'b1;
    #1;
    check("async_reset_test_busy", g[0].tbusy, 1'b0);
    check("async_reset_mul_a",     g[0].ma,    4'h0);
    check("async_reset_mul_b",     g[0].mb,    4'h0);
    check("async_reset_mul_start", g[0].mstart, 1'b0);
    check("async_reset_test_done", g[0].tdone, 1'b0);
    check("async_reset_pass",      g[0].tpass, 1'b0);
    check("async_reset_signature", g[0].sig,   8'h00);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("after_abort_no_done", g[0].tdone, 1'b0);

    // u0: full run, zero products; operand sequence 01, 02, 04.
    e = '{1'b1, 8'h00, 16, 114};
    g[0].exp_q.push_back(e);
    g[0].ops_q.push_back(8'h01);
    g[0].ops_q.push_back(8'h02);
    g[0].ops_q.push_back(8'h04);
    pulse_start(6'b000001);
    wait_done(0, 300);

    // u1/u2: product FF, two patterns; signature FF then 01.
    e = '{1'b1, 8'h01, 2, 16};
    g[1].exp_q.push_back(e);
    g[1].sig_q.push_back(8'h00);
    g[1].sig_q.push_back(8'hFF);
    e = '{1'b0, 8'h01, 2, 16};
    g[2].exp_q.push_back(e);
    pulse_start(6'b000110);
    wait_done(1, 100);
    wait_done(2, 100);

    // u3: busy never rises -> timeout after one start.
    e = '{1'b0, 8'h00, 1, 18};
    g[3].exp_q.push_back(e);
    pulse_start(6'b001000);
    wait_done(3, 40);

    // u4: signed products with model GOLDEN; a second request mid-run is dropped.
    e = '{1'b1, GOLD_REAL, 16, 114};
    g[4].exp_q.push_back(e);
    pulse_start(6'b010000);
    repeat (40) @(posedge clk);
    pulse_start(6'b010000);
    wait_done(4, 300);

    // u5: product bit 0 stuck at 0 against the same GOLDEN.
    e = '{1'b0, GOLD_STUCK, 16, 114};
    g[5].exp_q.push_back(e);
    pulse_start(6'b100000);
    wait_done(5, 300);

    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_bist_ctrl.md
# booth_bist_ctrl

Built-in self-test controller for the 4-bit Booth multiplier. While in test mode it generates pseudo-random operand pairs from an LFSR and issues each pair with a one-cycle start pulse. It waits out the multiplier's busy handshake, folds every product into an 8-bit MISR, and compares the final signature against a golden value to drive pass/done. It sits directly upstream of the multiplier's operand/start inputs and directly downstream of its product/busy outputs.

## Interface
- WIDTH, 4: operand width; product width is 2*WIDTH (only 4 is supported).
- NPAT, 16: number of operand pairs applied per test run (1..255).
- SEED, 8'h01: LFSR seed; a value of 0 is replaced by 8'h01.
- GOLDEN, 8'h00: expected final MISR signature.
- MAX_WAIT, 15: cycle limit for each handshake wait phase.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- test_start  in  1  one-cycle request to begin a run; ignored while a run is in progress
- mul_a  out  4  operand A to the multiplier
- mul_b  out  4  operand B to the multiplier
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_busy  in  1  multiplier busy
- mul_product  in  8  multiplier result; raw bits, signedness irrelevant to this block
- test_busy  out  1  high from acceptance of a run until done
- test_done  out  1  high from end of run until the next accepted test_start
- pass  out  1  valid while test_done=1: signature==GOLDEN and no timeout
- signature  out  8  current MISR value

## Operation
- LFSR, 8-bit: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Operands are mul_a=lfsr[7:4] and mul_b=lfsr[3:0]. The LFSR advances once per compacted pattern.
- MISR, 8-bit: next = {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]} ^ mul_product.
- States:
  - IDLE: outputs idle. On test_start: lfsr<=SEED (or 8'h01 if SEED is 0), misr<=0, pattern count<=0, test_done<=0, pass<=0 -> ISSUE.
  - ISSUE: mul_start=1 for exactly one cycle, wait counter cleared -> WAIT_HI.
  - WAIT_HI: wait for mul_busy=1 -> WAIT_LO. If MAX_WAIT cycles pass without it, set timeout flag -> FINISH.
  - WAIT_LO: wait for mul_busy=0; product is sampled in that cycle -> COMPACT. If MAX_WAIT cycles pass, set timeout -> FINISH.
  - COMPACT: update misr, advance lfsr, increment count. If count==NPAT -> FINISH, else -> ISSUE.
  - FINISH: pass<=(misr==GOLDEN)&&!timeout, test_done<=1 -> IDLE.
- mul_a/mul_b hold the current pattern stable from ISSUE through WAIT_LO.
- test_busy=1 in every state except IDLE.
- A timeout aborts the run: pass=0, and signature holds its value at the abort.

## Timing
- Reset (async, any state): state=IDLE, mul_a=0, mul_b=0, mul_start=0, test_busy=0, test_done=0, pass=0, signature=0, lfsr=SEED (8'h01 if SEED is 0), timeout=0.
- Reset mid-run: the run is abandoned immediately; no done or pass is produced.
- test_start is sampled only in IDLE. A test_start asserted while test_busy=1 is dropped, not queued.
- test_busy rises one cycle after test_start. mul_start rises in the cycle after that.
- Per-pattern cost with a multiplier of busy-high duration L: 1 (ISSUE) + 1 (WAIT_HI entry) + L + 1 (COMPACT) cycles, minimum.
- test_done and pass update in the same edge; test_busy falls on that same edge.
- mul_busy already high on the first WAIT_HI cycle is accepted, so a zero-gap multiplier is fine.
- mul_busy low for the first WAIT_HI cycle is not treated as completion; WAIT_HI requires an observed rising busy.

## Test plan
- Reset check: assert rst mid-run in WAIT_LO -> all outputs return to reset values asynchronously. After release, a new test_start completes a full run.
- Stub multiplier, busy high 4 cycles, product always 8'h00, NPAT=16, GOLDEN=8'h00 -> 16 mul_start pulses, signature=8'h00, test_done=1, pass=1.
- Stub product always 8'hFF, NPAT=2, GOLDEN=8'h01 -> signature 8'hFF after the first pattern and 8'h01 after the second, pass=1. Repeat with GOLDEN=8'h02 -> pass=0.
- Operand sequence, SEED=8'h01 -> first pattern mul_a=0,mul_b=1; second mul_a=0,mul_b=2; third mul_a=0,mul_b=4; each held stable while mul_busy=1.
- Timeout: stub never raises busy, MAX_WAIT=15 -> test_done rises within 18 cycles of test_start, pass=0, exactly one mul_start pulse.
- Real Booth multiplier, NPAT=16: GOLDEN is computed by a bench model applying signed 4x4 products through the same MISR -> pass=1. Inject a stuck-at-0 on product bit 0 -> pass=0. A test_start pulsed mid-run is ignored, so exactly 16 patterns are applied.
